// File: rtl/temporizador_pkg.sv
// Shared types and limits for the mode-4 countdown timer.
// Pure declarations: no logic, no latency.
package temporizador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } estado_t;

  localparam int MAX_SEG       = 59;
  localparam int MAX_MIN       = 99;
  localparam int ALARM_SECONDS = 30;
  localparam int SEG_W         = 6;
  localparam int MIN_W         = 7;

endpackage

// File: rtl/detector_flanco.sv
// Button conditioner: 2-flop synchronizer plus falling-edge detect, one-cycle pulse.
// Pulse is valid two edges after the fall, so the consumer acts on the third; no backpressure.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic pulso
);

  logic s1, s2, prev;

  // Preset to released so a button held through reset never yields a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= boton;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulso = prev & ~s2;

endmodule

// File: rtl/contador_temporizador.sv
// MM:SS countdown engine for mode 4: loads the configured value, counts down per 1 Hz tick.
// Button action lands on the 3rd clk edge after the press; tick effects are one edge; no backpressure.
module contador_temporizador #(
  parameter int MAX_SEG       = 59,
  parameter int MAX_MIN       = 99,
  parameter int ALARM_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick1hz,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       establecer,
  input  logic       cambiar,
  input  logic [5:0] newSegundosT,
  input  logic [6:0] newMinutosT,
  output logic [5:0] segundosT,
  output logic [6:0] minutosT,
  output logic       configuration,
  output logic       control,
  output logic       cierreAlarma
);
  import temporizador_pkg::*;

  localparam int CNT_W = $clog2(ALARM_SECONDS + 1);

  estado_t          state, state_n;
  logic [SEG_W-1:0] seg, seg_n, seg_c;
  logic [MIN_W-1:0] min, min_n, min_c;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pulso_e, pulso_c, modo, pe, pc;

  detector_flanco u_det_establecer (
    .clk   (clk),
    .rst   (rst),
    .boton (establecer),
    .pulso (pulso_e)
  );

  detector_flanco u_det_cambiar (
    .clk   (clk),
    .rst   (rst),
    .boton (cambiar),
    .pulso (pulso_c)
  );

  assign modo  = switch1 & switch2;
  assign pe    = pulso_e & modo;
  assign pc    = pulso_c & modo;
  assign seg_c = (newSegundosT > SEG_W'(MAX_SEG)) ? SEG_W'(MAX_SEG) : newSegundosT;
  assign min_c = (newMinutosT > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : newMinutosT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      seg   <= '0;
      min   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      seg   <= seg_n;
      min   <= min_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    seg_n   = seg;
    min_n   = min;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        seg_n = seg_c;
        min_n = min_c;
        if (pe && (seg_c != '0 || min_c != '0)) state_n = RUN;
      end
      RUN: begin
        // A press outranks a coincident tick: the value freezes as it was.
        if (pe) begin
          state_n = PAUSE;
        end else if (tick1hz) begin
          if (seg != '0) begin
            seg_n = seg - 6'd1;
          end else if (min != '0) begin
            min_n = min - 7'd1;
            seg_n = SEG_W'(MAX_SEG);
          end
          if (min == '0 && seg == 6'd1) begin
            state_n = ALARM;
            cnt_n   = '0;
          end
        end
      end
      PAUSE: begin
        if (pc)      state_n = IDLE;
        else if (pe) state_n = RUN;
      end
      ALARM: begin
        if (pe) begin
          state_n = IDLE;
        end else if (tick1hz) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_W'(ALARM_SECONDS - 1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign segundosT     = seg;
  assign minutosT      = min;
  assign configuration = (state != IDLE);
  assign control       = (state == RUN);
  assign cierreAlarma  = (state == ALARM);

endmodule

// File: tb/tb_contador_temporizador.sv
// Bench for contador_temporizador: directed scenarios plus randomized run against a
// behavioural model that tracks remaining time as a plain seconds total.
module tb_contador_temporizador;

  logic       clk = 1'b0;
  logic       rst, tick1hz, switch1, switch2, establecer, cambiar;
  logic [5:0] newSegundosT;
  logic [6:0] newMinutosT;
  logic [5:0] segundosT;
  logic [6:0] minutosT;
  logic       configuration, control, cierreAlarma;

  contador_temporizador dut (
    .clk           (clk),
    .rst           (rst),
    .tick1hz       (tick1hz),
    .switch1       (switch1),
    .switch2       (switch2),
    .establecer    (establecer),
    .cambiar       (cambiar),
    .newSegundosT  (newSegundosT),
    .newMinutosT   (newMinutosT),
    .segundosT     (segundosT),
    .minutosT      (minutosT),
    .configuration (configuration),
    .control       (control),
    .cierreAlarma  (cierreAlarma)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  int   m_st, m_min, m_sec, m_acnt;
  logic e1, e2, e3, c1, c2, c3;

  // Model: a button fall is acted on at the third edge; time kept as total seconds.
  task automatic model_edge();
    bit pe, pc;
    int cs, cm, t;
    if (rst) begin
      m_st = M_IDLE; m_min = 0; m_sec = 0; m_acnt = 0;
      e1 = 1; e2 = 1; e3 = 1; c1 = 1; c2 = 1; c3 = 1;
    end else begin
      pe = e3 && !e2 && switch1 && switch2;
      pc = c3 && !c2 && switch1 && switch2;
      e3 = e2; e2 = e1; e1 = establecer;
      c3 = c2; c2 = c1; c1 = cambiar;
      cs = (int'(newSegundosT) > 59) ? 59 : int'(newSegundosT);
      cm = (int'(newMinutosT) > 99) ? 99 : int'(newMinutosT);
      case (m_st)
        M_IDLE: begin
          m_sec = cs; m_min = cm;
          if (pe && (cs + cm) > 0) m_st = M_RUN;
        end
        M_RUN: begin
          if (pe) m_st = M_PAUSE;
          else if (tick1hz) begin
            t = m_min * 60 + m_sec;
            if (t > 0) t = t - 1;
            m_min = t / 60; m_sec = t % 60;
            if (t == 0) begin m_st = M_ALARM; m_acnt = 0; end
          end
        end
        M_PAUSE: begin
          if (pc) m_st = M_IDLE;
          else if (pe) m_st = M_RUN;
        end
        default: begin
          if (pe) m_st = M_IDLE;
          else if (tick1hz) begin
            m_acnt = m_acnt + 1;
            if (m_acnt == 30) m_st = M_IDLE;
          end
        end
      endcase
    end
  endtask

  function automatic logic [15:0] obs();
    return {minutosT, segundosT, configuration, control, cierreAlarma};
  endfunction

  function automatic logic [15:0] pack(input int mm, input int ss, input logic [2:0] f);
    return {7'(mm), 6'(ss), f};
  endfunction

  function automatic logic [15:0] model_vec();
    return pack(m_min, m_sec, {m_st != M_IDLE, m_st == M_RUN, m_st == M_ALARM});
  endfunction

  function automatic string fmt(input logic [15:0] v);
    return $sformatf("%0d:%0d cfg/ctl/alm=%b", v[15:9], v[8:3], v[2:0]);
  endfunction

  task automatic step(input logic e, input logic c, input logic t);
    @(negedge clk);
    establecer = e; cambiar = c; tick1hz = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press_e(input logic t_last);
    step(0, 1, 0); step(1, 1, 0); step(1, 1, t_last);
  endtask

  task automatic press_c();
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
  endtask

  task automatic press_both();
    step(0, 0, 0); step(1, 1, 0); step(1, 1, 0);
  endtask

  task automatic test_reset();
    logic [15:0] want;
    rst = 1; switch1 = 1; switch2 = 1; newMinutosT = 5; newSegundosT = 7;
    step(1, 1, 0); step(1, 1, 0);
    want = pack(0, 0, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL reset: got %s want %s", fmt(obs()), fmt(want)); end
    rst = 0;
    step(1, 1, 0);
    want = pack(5, 7, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL idle_follow: got %s want %s", fmt(obs()), fmt(want)); end
  endtask

  task automatic test_load();
    logic [15:0] want;
    newMinutosT = 1; newSegundosT = 2;
    step(1, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
    checks++;
    if (control !== 1'b0) begin errors++; $display("FAIL press_edge2: got control=%b want 0", control); end
    step(0, 1, 0);
    want = pack(1, 2, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL press_edge3: got %s want %s", fmt(obs()), fmt(want)); end
    repeat (6) step(0, 1, 0);
    step(1, 1, 0);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL hold_single: got %s want %s", fmt(obs()), fmt(want)); end
    repeat (3) step(1, 1, 1);
    want = pack(0, 59, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL borrow: got %s want %s", fmt(obs()), fmt(want)); end
  endtask

  task automatic test_alarm();
    logic [15:0] want;
    press_e(0); press_c();
    newMinutosT = 0; newSegundosT = 2;
    step(1, 1, 0);
    press_e(1);
    want = pack(0, 2, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL load_tick: got %s want %s", fmt(obs()), fmt(want)); end
    step(1, 1, 1); step(1, 1, 1);
    want = pack(0, 0, 3'b101);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL alarm_entry: got %s want %s", fmt(obs()), fmt(want)); end
    repeat (29) step(1, 1, 1);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL alarm_hold29: got %s want %s", fmt(obs()), fmt(want)); end
    step(1, 1, 1);
    want = pack(0, 0, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL alarm_timeout: got %s want %s", fmt(obs()), fmt(want)); end
    press_e(0);
    step(1, 1, 1); step(1, 1, 1);
    repeat (5) step(1, 1, 1);
    press_e(0);
    want = pack(0, 0, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL alarm_button: got %s want %s", fmt(obs()), fmt(want)); end
  endtask

  task automatic test_pause();
    logic [15:0] want;
    newMinutosT = 0; newSegundosT = 10;
    step(1, 1, 0);
    press_e(0); press_e(0);
    repeat (5) step(1, 1, 1);
    want = pack(0, 10, 3'b100);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL pause_hold: got %s want %s", fmt(obs()), fmt(want)); end
    press_e(0); step(1, 1, 1);
    want = pack(0, 9, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL resume: got %s want %s", fmt(obs()), fmt(want)); end
    press_e(0); press_c();
    want = pack(0, 9, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL abort: got %s want %s", fmt(obs()), fmt(want)); end
    press_e(0); press_e(0); press_both();
    checks++;
    if (configuration !== 1'b0) begin errors++; $display("FAIL both_press: got cfg=%b want 0", configuration); end
  endtask

  task automatic test_boundary();
    logic [15:0] want;
    newMinutosT = 0; newSegundosT = 0;
    press_e(0);
    want = pack(0, 0, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL zero_load: got %s want %s", fmt(obs()), fmt(want)); end
    newMinutosT = 120; newSegundosT = 63;
    step(1, 1, 0);
    want = pack(99, 59, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL clamp_display: got %s want %s", fmt(obs()), fmt(want)); end
    press_e(0);
    switch2 = 0;
    press_e(0);
    want = pack(99, 59, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL mode_gate: got %s want %s", fmt(obs()), fmt(want)); end
    step(1, 1, 1);
    want = pack(99, 58, 3'b110);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL background: got %s want %s", fmt(obs()), fmt(want)); end
    switch2 = 1;
    press_e(0); press_c();
  endtask

  task automatic test_tick_press();
    logic [15:0] want;
    newMinutosT = 0; newSegundosT = 5;
    step(1, 1, 0);
    press_e(0); press_e(1);
    want = pack(0, 5, 3'b100);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL tick_vs_press: got %s want %s", fmt(obs()), fmt(want)); end
    press_c();
    newMinutosT = 3; newSegundosT = 15;
    step(1, 1, 0);
    press_e(0);
    step(0, 1, 0);
    rst = 1;
    step(1, 1, 0);
    want = pack(0, 0, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL rst_mid_run: got %s want %s", fmt(obs()), fmt(want)); end
    rst = 0;
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    want = pack(3, 15, 3'b000);
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL discard_press: got %s want %s", fmt(obs()), fmt(want)); end
  endtask

  task automatic test_random();
    logic e = 1, c = 1, t;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        switch1 = 1'($urandom_range(0, 1)); switch2 = 1'($urandom_range(0, 1));
      end else begin
        switch1 = 1; switch2 = 1;
      end
      if ($urandom_range(0, 19) == 0) begin
        newMinutosT  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
        newSegundosT = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 5) == 0) e = ~e;
      if ($urandom_range(0, 11) == 0) c = ~c;
      t = ($urandom_range(0, 2) == 0);
      step(e, c, t);
      checks++;
      if (obs() !== model_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %s want %s", i, fmt(obs()), fmt(model_vec()));
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; tick1hz = 0; switch1 = 0; switch2 = 0; establecer = 1; cambiar = 1;
    newSegundosT = 0; newMinutosT = 0;
    m_st = M_IDLE; m_min = 0; m_sec = 0; m_acnt = 0;
    e1 = 1; e2 = 1; e3 = 1; c1 = 1; c2 = 1; c3 = 1;
    test_reset();
    test_load();
    test_alarm();
    test_pause();
    test_boundary();
    test_tick_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_temporizador.md
Name: contador_temporizador

Overview:
Countdown engine for mode 4, the consumer side of the timer configuration path. It takes the MM:SS value edited by the timer configuration block (newMinutosT/newSegundosT), loads it on "establecer", and counts down once per 1 Hz tick. It feeds segundosT, minutosT, configuration, control and cierreAlarma back to the configuration block and to the display mux. Runs on the system clock, with the 1 Hz time base supplied as a single-cycle enable.

Parameters:
MAX_SEG, 59, highest seconds value; also the reload value on a minute borrow
MAX_MIN, 99, highest minutes value
ALARM_SECONDS, 30, number of ticks the alarm stays active before auto-return to IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick1hz  in  1  one-cycle pulse per second, synchronous to clk
switch1  in  1  mode select bit; mode 4 is active when switch1=1 and switch2=1
switch2  in  1  mode select bit
establecer  in  1  button, active-low, asynchronous to clk
cambiar  in  1  button, active-low, asynchronous to clk; aborts from PAUSE
newSegundosT  in  6  configured seconds
newMinutosT  in  7  configured minutes
segundosT  out  6  remaining seconds
minutosT  out  7  remaining minutes
configuration  out  1  0 = editing open (IDLE), 1 = value armed (RUN, PAUSE or ALARM)
control  out  1  1 only in RUN
cierreAlarma  out  1  1 only in ALARM

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; segundosT=0; minutosT=0; configuration=0; control=0; cierreAlarma=0.
  - Alarm counter=0.
  - Button synchronizers preset to 1 (released). rst has priority over every other event.
- Buttons:
  - Each button goes through a 2-flop synchronizer and then a falling-edge detector, giving a one-cycle "press".
  - A press is accepted only when switch1=1 and switch2=1; otherwise it is dropped.
  - The state/output change occurs on the 3rd rising clk edge after the input falls.
  - Holding a button produces exactly one press.
- All outputs are registered. configuration, control and cierreAlarma are decoded from the state register.
- IDLE:
  - segundosT/minutosT follow the clamped inputs each cycle: seconds = min(newSegundosT, MAX_SEG), minutes = min(newMinutosT, MAX_MIN).
  - establecer press with a clamped value of 00:00: ignored, stay in IDLE.
  - establecer press with any other value: load the clamped value, go to RUN. A tick in the same cycle does not decrement.
- RUN:
  - On tick1hz: if seconds > 0, seconds-1; else if minutes > 0, minutes-1 and seconds=MAX_SEG.
  - A tick that produces 00:00 moves to ALARM on the same edge. Outputs show 00:00, control=0, cierreAlarma=1.
  - establecer press goes to PAUSE. If a tick coincides with the press, the press wins and no decrement happens.
  - Switches leaving mode 4 do not stop counting; the timer keeps running in the background.
- PAUSE:
  - Ticks are ignored and the value holds.
  - establecer press goes to RUN.
  - cambiar press goes to IDLE.
  - If both presses occur in the same cycle, cambiar wins.
- ALARM:
  - Alarm counter clears on entry and increments per tick.
  - Return to IDLE on an establecer press, or on the tick that makes the counter reach ALARM_SECONDS, whichever comes first.
- Arithmetic: never underflow below 00:00; no wrap in RUN. Counter width is clog2(ALARM_SECONDS+1).
- rst asserted mid-RUN/ALARM gives IDLE and zeros on the next edge; any in-flight press is discarded.

Decomposition:
- Package temporizador_pkg holds:
  - state enum: IDLE, RUN, PAUSE, ALARM
  - constants MAX_SEG and MAX_MIN
  - widths SEG_W=6 and MIN_W=7
- One sub-module, detector_flanco: synchronizer plus falling-edge press pulse. It is instantiated twice, for establecer and cambiar.

Test Plan:
1. Assert rst for 2 cycles -> state=IDLE, all outputs 0. With newMinutosT=5 and newSegundosT=7, the IDLE display shows 05:07 one edge later.
2. Switches=11, inputs 01:02, pulse establecer -> on the 3rd edge after the falling input: control=1, configuration=1. After 3 ticks the output is 00:59.
3. Load 00:02, two ticks -> 00:00, cierreAlarma=1, control=0. After 30 further ticks, state=IDLE and cierreAlarma=0. Repeat and press establecer after 5 ticks -> IDLE immediately.
4. RUN at 00:10, press establecer -> PAUSE; 5 ticks leave 00:10. Press again: RUN, next tick gives 00:09. Pause again, press cambiar -> IDLE, configuration=0.
5. Inputs 00:00 plus press -> stays in IDLE. Inputs seconds=63, minutes=120 -> display/load 99:59. Press with switch2=0 -> ignored.
6. Tick coinciding with an establecer press in RUN -> PAUSE with value unchanged. rst mid-RUN at 03:15 -> 00:00 in IDLE on the next edge.
